// File: rtl/cosine_ci_ctrl.sv
// cosine_ci_ctrl
// Multi-cycle custom-instruction controller in front of the `cosine` stage.
// A request carries one single-precision operand. Operands in [0, 255] (and -0)
// are normalised and driven onto cos_angle. After LATENCY enabled edges the
// float result is captured from cos_result and returned with a one-cycle done
// pulse. Any other operand is answered at once with a canonical quiet NaN and
// err set; such an operand never reaches the cosine stage.
//
// Ports
//   clk, reset   : single rising-edge clock, asynchronous active-high reset
//   clk_en       : global enable; all registers hold while low
//   start, dataa : request strobe and float operand (sampled in IDLE only)
//   done, result : one-enabled-cycle completion pulse and returned float
//   err          : operand was rejected; held until next accepted request
//   busy         : high while a request is in RUN or DONE
//   cos_angle    : registered angle into the cosine stage
//   cos_clk_en   : clk_en forwarded to the cosine stage
//   cos_result   : float output of the cosine stage
module cosine_ci_ctrl #(
   parameter int unsigned LATENCY = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic        done,
   output logic [31:0] result,
   output logic        err,
   output logic        busy,
   output logic [31:0] cos_angle,
   output logic        cos_clk_en,
   input  logic [31:0] cos_result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] QNAN      = 32'h7fc0_0000;
   localparam logic [31:0] MAX_LEGAL = 32'h437f_0000;  // 255.0
   localparam logic [31:0] NEG_ZERO  = 32'h8000_0000;
   localparam logic [7:0]  CNT_INIT  = 8'(LATENCY - 1);

   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic        done_r, done_s;
   logic [31:0] result_r, result_s;
   logic        err_r, err_s;
   logic        busy_r, busy_s;
   logic [31:0] angle_r, angle_s;
   logic        legal_s;
   logic [31:0] norm_s;

   // Operand classification and normalisation. With the sign bit set an
   // unsigned compare against 255.0 always fails, so only -0 needs a special
   // case; every exp=0 encoding (zero or denormal) collapses to +0.
   always_comb begin
      legal_s = (dataa <= MAX_LEGAL) || (dataa == NEG_ZERO);
      if (dataa[30:23] == 8'd0) begin
         norm_s = 32'h0000_0000;
      end else begin
         norm_s = dataa;
      end
   end

   // Next-state and next-register-value logic; every register holds by default.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      done_s   = done_r;
      result_s = result_r;
      err_s    = err_r;
      angle_s  = angle_r;
      case (state_r)
         IDLE: begin
            if (start && legal_s) begin
               angle_s = norm_s;
               cnt_s   = CNT_INIT;
               err_s   = 1'b0;
               state_s = RUN;
            end else if (start) begin
               result_s = QNAN;
               err_s    = 1'b1;
               done_s   = 1'b1;
               state_s  = DONE;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == 8'd0) begin
               result_s = cos_result;
               done_s   = 1'b1;
               state_s  = DONE;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         DONE: begin
            done_s  = 1'b0;
            state_s = IDLE;
         end
         default: begin
            done_s  = 1'b0;
            state_s = IDLE;
         end
      endcase
      // busy is registered from the next state so it rises on the accepting edge
      busy_s = (state_s != IDLE);
   end

   // State and datapath registers, frozen while clk_en is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         cnt_r    <= 8'd0;
         done_r   <= 1'b0;
         result_r <= 32'h0000_0000;
         err_r    <= 1'b0;
         busy_r   <= 1'b0;
         angle_r  <= 32'h0000_0000;
      end else if (clk_en) begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         done_r   <= done_s;
         result_r <= result_s;
         err_r    <= err_s;
         busy_r   <= busy_s;
         angle_r  <= angle_s;
      end else begin
         state_r  <= state_r;
         cnt_r    <= cnt_r;
         done_r   <= done_r;
         result_r <= result_r;
         err_r    <= err_r;
         busy_r   <= busy_r;
         angle_r  <= angle_r;
      end
   end

   assign done       = done_r;
   assign result     = result_r;
   assign err        = err_r;
   assign busy       = busy_r;
   assign cos_angle  = angle_r;
   assign cos_clk_en = clk_en;

endmodule

// File: tb/tb_cosine_ci_ctrl.sv
// Directed testbench for cosine_ci_ctrl. A stand-in cosine stage (lookup table
// followed by an enable-gated delay line) supplies cos_result so that a fresh
// value is available exactly at the LATENCY-th enabled edge after cos_angle
// changes, and the stale value is still present one edge earlier.
module tb_cosine_ci_ctrl;

   localparam int LAT = 8;

   logic        clk;
   logic        reset;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa;
   logic        done;
   logic [31:0] result;
   logic        err;
   logic        busy;
   logic [31:0] cos_angle;
   logic        cos_clk_en;
   logic [31:0] cos_result;

   int total;
   int bad;

   logic [31:0] st [0:LAT-1];

   cosine_ci_ctrl #(.LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .start      (start),
      .dataa      (dataa),
      .done       (done),
      .result     (result),
      .err        (err),
      .busy       (busy),
      .cos_angle  (cos_angle),
      .cos_clk_en (cos_clk_en),
      .cos_result (cos_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stand-in cosine values (distinct per angle so early/late capture shows)
   function automatic logic [31:0] cos_lut(input logic [31:0] a);
      case (a)
         32'h0000_0000: cos_lut = 32'h3f80_0000;
         32'h3f80_0000: cos_lut = 32'h3f0a_5140;
         32'h3f00_0000: cos_lut = 32'h3f60_a940;
         32'h437f_0000: cos_lut = 32'hbf5c_bd6b;
         default:       cos_lut = 32'h3c00_0000;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < LAT; i++) st[i] = 32'h0000_0000;
   end

   always @(posedge clk) begin
      if (cos_clk_en) begin
         st[0] <= cos_lut(cos_angle);
         for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
      end
   end
   assign cos_result = st[LAT-2];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      int  n;
      bit  seen;
      reset = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = 32'h0;
      repeat (2) step();
      reset = 1'b0;
      step();
      total++;
      if ({done, err, busy} !== 3'b000 || result !== 32'h0 || cos_angle !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: done=%b err=%b busy=%b result=%h angle=%h, need all 0",
                  done, err, busy, result, cos_angle);
      end
      // start together with reset: reset wins
      reset = 1'b1; start = 1'b1; dataa = 32'h3f80_0000;
      step();
      reset = 1'b0; start = 1'b0;
      total++;
      if (busy !== 1'b0 || cos_angle !== 32'h0) begin
         bad++;
         $display("FAIL reset_beats_start: busy=%b angle=%h, need 0/0", busy, cos_angle);
      end
      // complete one request so result is non-zero, then reset mid-RUN
      start = 1'b1; dataa = 32'h3f80_0000;
      step();
      start = 1'b0;
      wait_done(n);
      step();
      start = 1'b1; dataa = 32'h3f00_0000;
      step();
      start = 1'b0;
      repeat (3) step();
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      total++;
      if ({done, err, busy} !== 3'b000 || result !== 32'h0 || cos_angle !== 32'h0) begin
         bad++;
         $display("FAIL async_reset: done=%b err=%b busy=%b result=%h angle=%h, need all 0",
                  done, err, busy, result, cos_angle);
      end
      #1;
      reset = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         step();
         if (done === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_kills_run: done_seen=%b busy=%b, need 0/0", seen, busy);
      end
   endtask

   task automatic test_legal();
      logic [31:0] ops   [7] = '{32'h3f80_0000, 32'h0000_0000, 32'h3f00_0000,
                                 32'h437f_0000, 32'h8000_0000, 32'h3f80_0000,
                                 32'h0000_0001};
      logic [31:0] angs  [7] = '{32'h3f80_0000, 32'h0000_0000, 32'h3f00_0000,
                                 32'h437f_0000, 32'h0000_0000, 32'h3f80_0000,
                                 32'h0000_0000};
      logic [31:0] res   [7] = '{32'h3f0a_5140, 32'h3f80_0000, 32'h3f60_a940,
                                 32'hbf5c_bd6b, 32'h3f80_0000, 32'h3f0a_5140,
                                 32'h3f80_0000};
      int n;
      for (int k = 0; k < 7; k++) begin
         start = 1'b1; dataa = ops[k];
         step();
         start = 1'b0;
         total++;
         if (busy !== 1'b1 || cos_angle !== angs[k] || err !== 1'b0) begin
            bad++;
            $display("FAIL legal_accept[%0d]: busy=%b angle=%h err=%b, need 1/%h/0",
                     k, busy, cos_angle, err, angs[k]);
         end
         wait_done(n);
         total++;
         if (n != LAT || result !== res[k] || err !== 1'b0) begin
            bad++;
            $display("FAIL legal_done[%0d]: latency=%0d result=%h err=%b, need %0d/%h/0",
                     k, n, result, err, LAT, res[k]);
         end
         step();
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== res[k]) begin
            bad++;
            $display("FAIL legal_after[%0d]: done=%b busy=%b result=%h, need 0/0/%h",
                     k, done, busy, result, res[k]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] ops [5] = '{32'h437f_0001, 32'h4380_0000, 32'hbf80_0000,
                               32'h7fc0_0000, 32'h7f80_0000};
      int n;
      start = 1'b1; dataa = 32'h3f00_0000;
      step();
      start = 1'b0;
      wait_done(n);
      step();
      for (int k = 0; k < 5; k++) begin
         start = 1'b1; dataa = ops[k];
         step();
         start = 1'b0;
         total++;
         if (done !== 1'b1 || err !== 1'b1 || result !== 32'h7fc0_0000 ||
             cos_angle !== 32'h3f00_0000) begin
            bad++;
            $display("FAIL illegal[%0d]: done=%b err=%b result=%h angle=%h, need 1/1/7fc00000/3f000000",
                     k, done, err, result, cos_angle);
         end
         step();
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_after[%0d]: done=%b busy=%b err=%b, need 0/0/1",
                     k, done, busy, err);
         end
      end
   endtask

   task automatic test_stall();
      int n;
      start = 1'b1; dataa = 32'h3f80_0000;
      step();
      start = 1'b0;
      repeat (3) step();
      clk_en = 1'b0;
      repeat (5) step();
      clk_en = 1'b1;
      total++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL stall_hold: done=%b busy=%b, need 0/1", done, busy);
      end
      wait_done(n);
      total++;
      if (3 + 5 + n != LAT + 5 || result !== 32'h3f0a_5140) begin
         bad++;
         $display("FAIL stall_done: cycles=%0d result=%h, need %0d/3f0a5140",
                  3 + 5 + n, result, LAT + 5);
      end
      clk_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (done !== 1'b1) begin
            bad++;
            $display("FAIL stall_done_stretch[%0d]: done=%b, need 1", k, done);
         end
      end
      clk_en = 1'b1;
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL stall_release: done=%b busy=%b, need 0/0", done, busy);
      end
   endtask

   task automatic test_ignored_start();
      int n;
      int dones;
      start = 1'b1; dataa = 32'h3f80_0000;
      step();
      start = 1'b0;
      repeat (2) step();
      start = 1'b1; dataa = 32'h3f00_0000;
      step();
      start = 1'b0;
      total++;
      if (cos_angle !== 32'h3f80_0000) begin
         bad++;
         $display("FAIL ignore_run_angle: angle=%h, need 3f800000", cos_angle);
      end
      wait_done(n);
      total++;
      if (3 + n != LAT || result !== 32'h3f0a_5140) begin
         bad++;
         $display("FAIL ignore_run_done: latency=%0d result=%h, need %0d/3f0a5140",
                  3 + n, result, LAT);
      end
      // start while in DONE must also be dropped
      start = 1'b1; dataa = 32'h3f00_0000;
      step();
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || cos_angle !== 32'h3f80_0000) begin
         bad++;
         $display("FAIL ignore_done_start: busy=%b done=%b angle=%h, need 0/0/3f800000",
                  busy, done, cos_angle);
      end
      dones = 0;
      repeat (15) begin
         step();
         if (done === 1'b1) dones++;
      end
      total++;
      if (dones != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL ignore_no_second: extra_dones=%0d busy=%b, need 0/0", dones, busy);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      start = 1'b1; dataa = 32'hbf80_0000;
      step();
      dataa = 32'h3f00_0000;
      step();
      total++;
      if (busy !== 1'b0 || err !== 1'b1) begin
         bad++;
         $display("FAIL b2b_gap: busy=%b err=%b, need 0/1", busy, err);
      end
      step();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || cos_angle !== 32'h3f00_0000 || err !== 1'b0) begin
         bad++;
         $display("FAIL b2b_accept: busy=%b angle=%h err=%b, need 1/3f000000/0",
                  busy, cos_angle, err);
      end
      wait_done(n);
      total++;
      if (n != LAT || result !== 32'h3f60_a940) begin
         bad++;
         $display("FAIL b2b_done: latency=%0d result=%h, need %0d/3f60a940", n, result, LAT);
      end
      start = 1'b1; dataa = 32'h0000_0000;
      step();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle: busy=%b, need 0", busy);
      end
      step();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || cos_angle !== 32'h0000_0000) begin
         bad++;
         $display("FAIL b2b_second: busy=%b angle=%h, need 1/00000000", busy, cos_angle);
      end
      wait_done(n);
      total++;
      if (n != LAT || result !== 32'h3f80_0000) begin
         bad++;
         $display("FAIL b2b_second_done: latency=%0d result=%h, need %0d/3f800000",
                  n, result, LAT);
      end
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_legal();
      test_illegal();
      test_stall();
      test_ignored_start();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
